// File: rtl/timer_peripheral.sv
// Memory-mapped reloadable 32-bit timer with overflow interrupt and free-running SYSTICK.
// Word registers at BASE_ADDR: 0x0 TH, 0x4 TL, 0x8 TCON {PEND, IE, EN}, 0xC SYSTICK.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    output logic        tick_o
);

    localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [31:0] sys_q, sys_d;
    logic [15:0] pre_q, pre_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;

    logic sel, wr, wr_th, wr_tl, wr_tcon;
    logic tick, ovf;
    logic unused_addr;

    // Byte lanes are not supported; the low address bits carry no meaning.
    assign unused_addr = ^addr_i[1:0];

    assign sel     = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr      = we_i & sel;
    assign wr_th   = wr & (addr_i[3:2] == 2'd0);
    assign wr_tl   = wr & (addr_i[3:2] == 2'd1);
    assign wr_tcon = wr & (addr_i[3:2] == 2'd2);

    assign tick = en_q & (pre_q == PreMax);
    // A CPU write to TL suppresses the tick's increment/reload and its overflow.
    assign ovf  = tick & ~wr_tl & (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        pre_d = 16'd0;
        if (en_q && !tick) begin
            pre_d = pre_q + 16'd1;
        end
    end

    always_comb begin
        th_d = th_q;
        if (wr_th) begin
            th_d = wdata_i;
        end

        tl_d = tl_q;
        if (wr_tl) begin
            tl_d = wdata_i;
        end else if (ovf) begin
            tl_d = th_q;
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end

        en_d   = en_q;
        ie_d   = ie_q;
        pend_d = pend_q;
        if (wr_tcon) begin
            en_d = wdata_i[0];
            ie_d = wdata_i[1];
            if (wdata_i[2]) begin
                pend_d = 1'b0;
            end
        end
        if (ovf) begin
            pend_d = 1'b1;
        end

        sys_d = sys_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            sys_q  <= 32'd0;
            pre_q  <= 16'd0;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            sys_q  <= sys_d;
            pre_q  <= pre_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        if (sel) begin
            unique case (addr_i[3:2])
                2'd0:    rdata_o = th_q;
                2'd1:    rdata_o = tl_q;
                2'd2:    rdata_o = {29'd0, pend_q, ie_q, en_q};
                default: rdata_o = sys_q;
            endcase
        end
    end

    assign irq_o  = pend_q & ie_q;
    assign tick_o = tick;

endmodule

// File: tb/tb_timer_peripheral.sv
// Bench for timer_peripheral: one instance with PRESCALE=1, one with PRESCALE=4.
// Expected values are queued as stimulus is applied and popped when the output is sampled.
module tb_timer_peripheral;

    localparam logic [31:0] Base = 32'h4000_0000;
    localparam logic [31:0] OffTh = 32'h0;
    localparam logic [31:0] OffTl = 32'h4;
    localparam logic [31:0] OffTcon = 32'h8;
    localparam logic [31:0] OffSys = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr1 = Base, wdata1 = '0, rdata1;
    logic        we1 = 1'b0, irq1, tick1;
    logic [31:0] addr4 = Base, wdata4 = '0, rdata4;
    logic        we4 = 1'b0, irq4, tick4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    timer_peripheral #(.BASE_ADDR(Base), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .addr_i(addr1), .wdata_i(wdata1), .we_i(we1),
        .rdata_o(rdata1), .irq_o(irq1), .tick_o(tick1)
    );

    timer_peripheral #(.BASE_ADDR(Base), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .addr_i(addr4), .wdata_i(wdata4), .we_i(we4),
        .rdata_o(rdata4), .irq_o(irq4), .tick_o(tick4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        addr1 = a;
        #1;
        check_eq(tag, rdata1, exp_q.pop_front());
    endtask

    task automatic rd4(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        addr4 = a;
        #1;
        check_eq(tag, rdata4, exp_q.pop_front());
    endtask

    task automatic sig(input string tag, input logic obs, input logic exp);
        exp_q.push_back({31'd0, exp});
        check_eq(tag, {31'd0, obs}, exp_q.pop_front());
    endtask

    // Drives a write at the next negedge; returns just after the capturing posedge.
    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr1 = a;
        wdata1 = d;
        we1 = 1'b1;
        @(posedge clk);
        #1 we1 = 1'b0;
    endtask

    task automatic wr4(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr4 = a;
        wdata4 = d;
        we4 = 1'b1;
        @(posedge clk);
        #1 we4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        rd1("rst_th", Base + OffTh, 32'h0);
        rd1("rst_tl", Base + OffTl, 32'h0);
        rd1("rst_tcon", Base + OffTcon, 32'h0);
        sig("rst_irq", irq1, 1'b0);
        sig("rst_tick", tick1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rd1("systick_5", Base + OffSys, 32'd5);

        // PRESCALE=4: tick every 4th cycle
        wr4(Base + OffTcon, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            sig("p4_tick", tick4, (k % 4) == 3);
            if (k == 4) rd4("p4_tl_4", Base + OffTl, 32'd1);
            if (k == 8) rd4("p4_tl_8", Base + OffTl, 32'd2);
            if (k == 12) rd4("p4_tl_12", Base + OffTl, 32'd3);
        end

        // Overflow, reload and PEND clear
        wr1(Base + OffTh, 32'hFFFF_FFF0);
        wr1(Base + OffTl, 32'hFFFF_FFFE);
        wr1(Base + OffTcon, 32'h3);
        rd1("ov_tl0", Base + OffTl, 32'hFFFF_FFFE);
        rd1("ov_tcon0", Base + OffTcon, 32'h3);
        @(posedge clk);
        #1;
        rd1("ov_tl1", Base + OffTl, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rd1("ov_reload", Base + OffTl, 32'hFFFF_FFF0);
        rd1("ov_pend", Base + OffTcon, 32'h7);
        sig("ov_irq", irq1, 1'b1);
        wr1(Base + OffTcon, 32'h7);
        rd1("clr_tcon", Base + OffTcon, 32'h3);
        sig("clr_irq", irq1, 1'b0);
        wr1(Base + OffTcon, 32'h0);

        // Pending with IE=0, then enable IE
        wr1(Base + OffTl, 32'hFFFF_FFFF);
        wr1(Base + OffTcon, 32'h1);
        @(posedge clk);
        #1;
        rd1("ie0_tcon", Base + OffTcon, 32'h5);
        sig("ie0_irq", irq1, 1'b0);
        rd1("ie0_tl", Base + OffTl, 32'hFFFF_FFF0);
        wr1(Base + OffTcon, 32'h3);
        sig("ie1_irq", irq1, 1'b1);
        rd1("ie1_tcon", Base + OffTcon, 32'h7);
        wr1(Base + OffTcon, 32'h4);
        rd1("ie_off_tcon", Base + OffTcon, 32'h0);
        sig("ie_off_irq", irq1, 1'b0);

        // Collision: TL write on overflow cycle
        wr1(Base + OffTl, 32'hFFFF_FFFF);
        wr1(Base + OffTcon, 32'h1);
        wr1(Base + OffTl, 32'h5);
        rd1("col_tl", Base + OffTl, 32'h5);
        rd1("col_tl_pend", Base + OffTcon, 32'h1);
        sig("col_tick_on", tick1, 1'b1);
        wr1(Base + OffTcon, 32'h0);
        sig("col_tick_off", tick1, 1'b0);
        rd1("col_dis_tl", Base + OffTl, 32'h6);

        // Collision: TCON clear on overflow cycle (set wins)
        wr1(Base + OffTl, 32'hFFFF_FFFF);
        wr1(Base + OffTcon, 32'h1);
        wr1(Base + OffTcon, 32'h7);
        rd1("col_pend", Base + OffTcon, 32'h7);
        rd1("col_pend_tl", Base + OffTl, 32'hFFFF_FFF0);
        wr1(Base + OffTcon, 32'h4);
        rd1("col_pend_clr", Base + OffTcon, 32'h0);

        // Collision: TH write on overflow cycle reloads old TH
        wr1(Base + OffTl, 32'hFFFF_FFFF);
        wr1(Base + OffTcon, 32'h1);
        wr1(Base + OffTh, 32'h9);
        rd1("col_th_tl", Base + OffTl, 32'hFFFF_FFF0);
        rd1("col_th_th", Base + OffTh, 32'h9);
        rd1("col_th_pend", Base + OffTcon, 32'h5);
        wr1(Base + OffTcon, 32'h4);

        // Out-of-window write
        wr1(Base + 32'h10, 32'hDEAD_BEEF);
        rd1("oow_th", Base + OffTh, 32'h9);
        rd1("oow_tl", Base + OffTl, 32'hFFFF_FFF1);
        rd1("oow_tcon", Base + OffTcon, 32'h0);
        rd1("oow_rd", Base + 32'h10, 32'h0);

        // Asynchronous reset mid-count
        wr1(Base + OffTcon, 32'h3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        rd1("arst_th", Base + OffTh, 32'h0);
        rd1("arst_tl", Base + OffTl, 32'h0);
        rd1("arst_tcon", Base + OffTcon, 32'h0);
        rd1("arst_sys", Base + OffSys, 32'h0);
        sig("arst_irq", irq1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
